// File: rtl/control_seq_pkg.sv
// ---------------------------------------------------------------------------
// control_seq_pkg
//   Shared definitions for the hardwired control sequencer:
//   - sequencer state encoding
//   - instruction opcodes
//   - RF / ARF / DR function-select codes and ALU operation codes
//   - active-low register-select encodings and mux select names
//   - the control-word struct that carries every datapath control input
// ---------------------------------------------------------------------------
package control_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH1 = 3'd1,
        S_FETCH2 = 3'd2,
        S_EXEC   = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Opcodes, IR[15:10]
    localparam logic [5:0] OP_BRA = 6'h00;
    localparam logic [5:0] OP_BNE = 6'h01;
    localparam logic [5:0] OP_BEQ = 6'h02;
    localparam logic [5:0] OP_IMM = 6'h03;
    localparam logic [5:0] OP_ADD = 6'h04;
    localparam logic [5:0] OP_SUB = 6'h05;
    localparam logic [5:0] OP_AND = 6'h06;
    localparam logic [5:0] OP_ORR = 6'h07;
    localparam logic [5:0] OP_XOR = 6'h08;
    localparam logic [5:0] OP_LD  = 6'h09;
    localparam logic [5:0] OP_ST  = 6'h0A;
    localparam logic [5:0] OP_HLT = 6'h0B;

    // Register file function select
    localparam logic [2:0] RF_FUN_DEC         = 3'b000;
    localparam logic [2:0] RF_FUN_INC         = 3'b001;
    localparam logic [2:0] RF_FUN_LOAD        = 3'b010;
    localparam logic [2:0] RF_FUN_CLEAR       = 3'b011;
    localparam logic [2:0] RF_FUN_LOADLOW_CLR = 3'b100;

    // Address register file function select
    localparam logic [1:0] ARF_FUN_DEC   = 2'b00;
    localparam logic [1:0] ARF_FUN_INC   = 2'b01;
    localparam logic [1:0] ARF_FUN_LOAD  = 2'b10;
    localparam logic [1:0] ARF_FUN_CLEAR = 2'b11;

    // Data register function select
    localparam logic [1:0] DR_FUN_CLEAR = 2'b00;
    localparam logic [1:0] DR_FUN_LOAD  = 2'b01;

    // ALU operation codes (low four bits of ALU_FunSel)
    localparam logic [3:0] ALU_PASS_A = 4'h0;
    localparam logic [3:0] ALU_ADD    = 4'h4;
    localparam logic [3:0] ALU_SUB    = 4'h5;
    localparam logic [3:0] ALU_AND    = 4'h6;
    localparam logic [3:0] ALU_ORR    = 4'h7;
    localparam logic [3:0] ALU_XOR    = 4'h8;

    // Active-low register enables
    localparam logic [3:0] RF_SEL_NONE  = 4'b1111;
    localparam logic [3:0] RF_SCR_NONE  = 4'b1111;
    localparam logic [2:0] ARF_SEL_NONE = 3'b111;
    localparam logic [2:0] ARF_SEL_PC   = 3'b011;
    localparam logic [2:0] ARF_SEL_AR   = 3'b101;
    localparam logic [2:0] ARF_SEL_SP   = 3'b110;

    // ARF output selects
    localparam logic [1:0] ARF_OUT_PC = 2'b00;
    localparam logic [1:0] ARF_OUT_AR = 2'b10;
    localparam logic [1:0] ARF_OUT_SP = 2'b11;

    // Mux selects
    localparam logic [1:0] MUXA_ALU    = 2'd0;
    localparam logic [1:0] MUXA_ARF    = 2'd1;
    localparam logic [1:0] MUXA_DR     = 2'd2;
    localparam logic [1:0] MUXA_IMM    = 2'd3;
    localparam logic [1:0] MUXB_ALU    = 2'd0;
    localparam logic [1:0] MUXB_ARF    = 2'd1;
    localparam logic [1:0] MUXB_DR     = 2'd2;
    localparam logic [1:0] MUXB_IMM    = 2'd3;
    localparam logic [1:0] MUXC_ALU_LO = 2'd0;
    localparam logic [1:0] MUXC_ALU_HI = 2'd1;
    localparam logic       MUXD_RF_A   = 1'b0;
    localparam logic       MUXD_ARF_C  = 1'b1;

    typedef struct packed {
        logic [2:0] rf_out_a_sel;
        logic [2:0] rf_out_b_sel;
        logic [2:0] rf_fun_sel;
        logic [3:0] rf_reg_sel;
        logic [3:0] rf_scr_sel;
        logic [4:0] alu_fun_sel;
        logic       alu_wf;
        logic [1:0] arf_out_c_sel;
        logic [1:0] arf_out_d_sel;
        logic [1:0] arf_fun_sel;
        logic [2:0] arf_reg_sel;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic [1:0] mux_c_sel;
        logic       mux_d_sel;
        logic       ir_write;
        logic       ir_lh;
        logic       mem_cs;
        logic       mem_wr;
        logic       dr_e;
        logic [1:0] dr_fun_sel;
        logic       halted;
        logic       illegal_op;
    } ctrl_word_t;

    // Idle control word: nothing is written, memory deselected.
    function automatic ctrl_word_t ctrl_default();
        ctrl_word_t c;
        c             = '0;
        c.rf_reg_sel  = RF_SEL_NONE;
        c.rf_scr_sel  = RF_SCR_NONE;
        c.arf_reg_sel = ARF_SEL_NONE;
        c.mem_cs      = 1'b1;
        return c;
    endfunction

    // Register code 0..3 (R1..R4) maps to enable bit 3..0, active low.
    function automatic logic [3:0] rf_sel_onehot(input logic [1:0] code);
        return ~(4'b1000 >> code);
    endfunction

    function automatic logic is_defined_op(input logic [5:0] op);
        return (op <= OP_HLT);
    endfunction

    function automatic logic [3:0] alu_op_for(input logic [5:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_ORR:  return ALU_ORR;
            OP_XOR:  return ALU_XOR;
            default: return ALU_PASS_A;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_seq_decoder.sv
// ---------------------------------------------------------------------------
// seq_decoder
//   Purely combinational map from (state, instruction, ALU flags, start)
//   to the full datapath control word.
//   Parameters: FETCH_LOW_FIRST - byte order of the two-byte fetch
//               ALU_32BIT       - value of ALU_FunSel[4] for ALU operations
//   Ports: state (in)  current sequencer state
//          ir    (in)  16-bit instruction register contents
//          flags (in)  {Z,C,N,O}
//          start (in)  start request (already qualified by reset)
//          ctrl  (out) control word
// ---------------------------------------------------------------------------
module seq_decoder
    import control_seq_pkg::*;
#(
    parameter bit FETCH_LOW_FIRST = 1'b1,
    parameter bit ALU_32BIT       = 1'b1
) (
    input  state_t      state,
    input  logic [15:0] ir,
    input  logic [3:0]  flags,
    input  logic        start,
    output ctrl_word_t  ctrl
);

    logic [5:0] op;
    logic       s_bit;
    logic [1:0] dst;
    logic [1:0] src1;
    logic [1:0] src2;
    logic [1:0] rx;
    logic       z_flag;
    logic       branch_taken;
    logic       unused_bits;

    assign op     = ir[15:10];
    assign s_bit  = ir[9];
    assign dst    = ir[8:7];
    assign src1   = ir[6:5];
    assign src2   = ir[4:3];
    assign rx     = ir[9:8];
    assign z_flag = flags[3];

    // The immediate byte goes straight to the datapath, and only Z steers
    // control flow, so these bits are deliberately not decoded here.
    assign unused_bits = ^{ir[2:0], flags[2:0]};

    assign branch_taken = (op == OP_BRA)
                        | ((op == OP_BNE) & ~z_flag)
                        | ((op == OP_BEQ) &  z_flag);

    always_comb begin
        ctrl = ctrl_default();
        case (state)
            S_IDLE: begin
                if (start) begin
                    ctrl.arf_reg_sel = ARF_SEL_PC;
                    ctrl.arf_fun_sel = ARF_FUN_CLEAR;
                end
            end
            S_FETCH1, S_FETCH2: begin
                ctrl.arf_out_d_sel = ARF_OUT_PC;
                ctrl.mem_cs        = 1'b0;
                ctrl.mem_wr        = 1'b0;
                ctrl.ir_write      = 1'b1;
                ctrl.arf_reg_sel   = ARF_SEL_PC;
                ctrl.arf_fun_sel   = ARF_FUN_INC;
                // Second byte goes to the half opposite to the first one.
                ctrl.ir_lh = (state == S_FETCH2) ? FETCH_LOW_FIRST : ~FETCH_LOW_FIRST;
            end
            S_EXEC: begin
                case (op)
                    OP_BRA, OP_BNE, OP_BEQ: begin
                        if (branch_taken) begin
                            ctrl.mux_b_sel   = MUXB_IMM;
                            ctrl.arf_reg_sel = ARF_SEL_PC;
                            ctrl.arf_fun_sel = ARF_FUN_LOAD;
                        end
                    end
                    OP_IMM: begin
                        ctrl.mux_a_sel  = MUXA_IMM;
                        ctrl.rf_fun_sel = RF_FUN_LOADLOW_CLR;
                        ctrl.rf_reg_sel = rf_sel_onehot(rx);
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_XOR: begin
                        ctrl.rf_out_a_sel = {1'b0, src1};
                        ctrl.rf_out_b_sel = {1'b0, src2};
                        ctrl.mux_d_sel    = MUXD_RF_A;
                        ctrl.alu_fun_sel  = {ALU_32BIT, alu_op_for(op)};
                        ctrl.alu_wf       = s_bit;
                        ctrl.mux_a_sel    = MUXA_ALU;
                        ctrl.rf_fun_sel   = RF_FUN_LOAD;
                        ctrl.rf_reg_sel   = rf_sel_onehot(dst);
                    end
                    OP_LD: begin
                        ctrl.arf_out_d_sel = ARF_OUT_AR;
                        ctrl.mem_cs        = 1'b0;
                        ctrl.dr_e          = 1'b1;
                        ctrl.dr_fun_sel    = DR_FUN_LOAD;
                    end
                    OP_ST: begin
                        // Register value passes through the ALU to the memory data bus.
                        ctrl.rf_out_a_sel  = {1'b0, rx};
                        ctrl.mux_d_sel     = MUXD_RF_A;
                        ctrl.alu_fun_sel   = {ALU_32BIT, ALU_PASS_A};
                        ctrl.mux_c_sel     = MUXC_ALU_LO;
                        ctrl.arf_out_d_sel = ARF_OUT_AR;
                        ctrl.mem_cs        = 1'b0;
                        ctrl.mem_wr        = 1'b1;
                    end
                    OP_HLT: begin
                    end
                    default: begin
                        ctrl.illegal_op = 1'b1;
                    end
                endcase
            end
            S_EXEC2: begin
                ctrl.mux_a_sel  = MUXA_DR;
                ctrl.rf_fun_sel = RF_FUN_LOAD;
                ctrl.rf_reg_sel = rf_sel_onehot(rx);
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Hardwired control unit for the ALU-system datapath. Fetches a 16-bit
//   instruction as two bytes, then runs a one- or two-cycle execute step.
//   Output names match the datapath control inputs one to one.
//
//   Build option: define CTRL_SEQ_ILLEGAL_TRAP_EN to make an undefined
//   opcode stop the machine in HALT; otherwise it behaves as a NOP.
//
//   Parameters: FETCH_LOW_FIRST (1: first byte -> IR low half)
//               ALU_32BIT       (ALU_FunSel[4] for ALU operations)
//   Inputs : Clock, Reset (async, active low), Start, IROut[15:0],
//            ALU_FlagsOut[3:0] = {Z,C,N,O}
//   Outputs: RF_*, ALU_*, ARF_*, Mux*Sel, IR_Write, IR_LH, Mem_CS, Mem_WR,
//            DR_E, DR_FunSel, Halted, IllegalOp, StateOut[2:0]
// ---------------------------------------------------------------------------
module control_sequencer
    import control_seq_pkg::*;
#(
    parameter bit FETCH_LOW_FIRST = 1'b1,
    parameter bit ALU_32BIT       = 1'b1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALU_FlagsOut,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic [1:0]  MuxCSel,
    output logic        MuxDSel,
    output logic        IR_Write,
    output logic        IR_LH,
    output logic        Mem_CS,
    output logic        Mem_WR,
    output logic        DR_E,
    output logic [1:0]  DR_FunSel,
    output logic        Halted,
    output logic        IllegalOp,
    output logic [2:0]  StateOut
);

    state_t     state;
    state_t     next_state;
    ctrl_word_t ctrl;
    logic [5:0] opcode;
    logic       start_gated;

    assign opcode = IROut[15:10];

    // While reset is held the IDLE state must show the plain default word,
    // so a simultaneous Start cannot leak a PC clear onto the datapath.
    assign start_gated = Start & Reset;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start_gated) begin
                    next_state = S_FETCH1;
                end
            end
            S_FETCH1: next_state = S_FETCH2;
            S_FETCH2: next_state = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_LD) begin
                    next_state = S_EXEC2;
                end else if (opcode == OP_HLT) begin
                    next_state = S_HALT;
                end else if (!is_defined_op(opcode)) begin
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
                    next_state = S_HALT;
`else
                    next_state = S_FETCH1;
`endif
                end else begin
                    next_state = S_FETCH1;
                end
            end
            S_EXEC2: next_state = S_FETCH1;
            S_HALT: begin
                if (start_gated) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    seq_decoder #(
        .FETCH_LOW_FIRST (FETCH_LOW_FIRST),
        .ALU_32BIT       (ALU_32BIT)
    ) u_decoder (
        .state (state),
        .ir    (IROut),
        .flags (ALU_FlagsOut),
        .start (start_gated),
        .ctrl  (ctrl)
    );

    assign RF_OutASel  = ctrl.rf_out_a_sel;
    assign RF_OutBSel  = ctrl.rf_out_b_sel;
    assign RF_FunSel   = ctrl.rf_fun_sel;
    assign RF_RegSel   = ctrl.rf_reg_sel;
    assign RF_ScrSel   = ctrl.rf_scr_sel;
    assign ALU_FunSel  = ctrl.alu_fun_sel;
    assign ALU_WF      = ctrl.alu_wf;
    assign ARF_OutCSel = ctrl.arf_out_c_sel;
    assign ARF_OutDSel = ctrl.arf_out_d_sel;
    assign ARF_FunSel  = ctrl.arf_fun_sel;
    assign ARF_RegSel  = ctrl.arf_reg_sel;
    assign MuxASel     = ctrl.mux_a_sel;
    assign MuxBSel     = ctrl.mux_b_sel;
    assign MuxCSel     = ctrl.mux_c_sel;
    assign MuxDSel     = ctrl.mux_d_sel;
    assign IR_Write    = ctrl.ir_write;
    assign IR_LH       = ctrl.ir_lh;
    assign Mem_CS      = ctrl.mem_cs;
    assign Mem_WR      = ctrl.mem_wr;
    assign DR_E        = ctrl.dr_e;
    assign DR_FunSel   = ctrl.dr_fun_sel;
    assign Halted      = ctrl.halted;
    assign IllegalOp   = ctrl.illegal_op;
    assign StateOut    = state;

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//   Directed, table-driven bench for control_sequencer. Each instruction
//   record carries its hand-computed EXEC (and EXEC2) control outputs and
//   whether the machine should land in HALT afterwards. Reset, start and
//   halt behaviour are covered by short hand-written sequences.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    // Encodings of the datapath control fields
    localparam logic [2:0] RF_LOAD    = 3'b010;
    localparam logic [2:0] RF_LOADLOW = 3'b100;
    localparam logic [1:0] ARF_INC    = 2'b01;
    localparam logic [1:0] ARF_LOAD   = 2'b10;
    localparam logic [1:0] ARF_CLEAR  = 2'b11;
    localparam logic [1:0] DR_LOAD    = 2'b01;
    localparam logic [1:0] OUT_AR     = 2'b10;

`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [15:0] IROut;
    logic [3:0]  ALU_FlagsOut;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic [1:0]  MuxASel, MuxBSel, MuxCSel;
    logic        MuxDSel;
    logic        IR_Write, IR_LH, Mem_CS, Mem_WR, DR_E;
    logic [1:0]  DR_FunSel;
    logic        Halted, IllegalOp;
    logic [2:0]  StateOut;

    typedef struct packed {
        logic [2:0] out_a;
        logic [2:0] out_b;
        logic [2:0] rf_fun;
        logic [3:0] rf_reg;
        logic [3:0] rf_scr;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [1:0] arf_c;
        logic [1:0] arf_d;
        logic [1:0] arf_fun;
        logic [2:0] arf_reg;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic [1:0] mux_c;
        logic       mux_d;
        logic       ir_write;
        logic       ir_lh;
        logic       mem_cs;
        logic       mem_wr;
        logic       dr_e;
        logic [1:0] dr_fun;
        logic       halted;
        logic       illegal;
        logic [2:0] st;
    } outs_t;

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic [3:0]  flags;
        outs_t       exec;
        bit          has_exec2;
        outs_t       exec2;
        bit          to_halt;
    } vec_t;

    outs_t actual;
    vec_t  vecs[$];
    int    num_checks = 0;
    int    num_fail   = 0;

    control_sequencer dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start        (Start),
        .IROut        (IROut),
        .ALU_FlagsOut (ALU_FlagsOut),
        .RF_OutASel   (RF_OutASel),
        .RF_OutBSel   (RF_OutBSel),
        .RF_FunSel    (RF_FunSel),
        .RF_RegSel    (RF_RegSel),
        .RF_ScrSel    (RF_ScrSel),
        .ALU_FunSel   (ALU_FunSel),
        .ALU_WF       (ALU_WF),
        .ARF_OutCSel  (ARF_OutCSel),
        .ARF_OutDSel  (ARF_OutDSel),
        .ARF_FunSel   (ARF_FunSel),
        .ARF_RegSel   (ARF_RegSel),
        .MuxASel      (MuxASel),
        .MuxBSel      (MuxBSel),
        .MuxCSel      (MuxCSel),
        .MuxDSel      (MuxDSel),
        .IR_Write     (IR_Write),
        .IR_LH        (IR_LH),
        .Mem_CS       (Mem_CS),
        .Mem_WR       (Mem_WR),
        .DR_E         (DR_E),
        .DR_FunSel    (DR_FunSel),
        .Halted       (Halted),
        .IllegalOp    (IllegalOp),
        .StateOut     (StateOut)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always_comb begin
        actual          = '0;
        actual.out_a    = RF_OutASel;
        actual.out_b    = RF_OutBSel;
        actual.rf_fun   = RF_FunSel;
        actual.rf_reg   = RF_RegSel;
        actual.rf_scr   = RF_ScrSel;
        actual.alu_fun  = ALU_FunSel;
        actual.alu_wf   = ALU_WF;
        actual.arf_c    = ARF_OutCSel;
        actual.arf_d    = ARF_OutDSel;
        actual.arf_fun  = ARF_FunSel;
        actual.arf_reg  = ARF_RegSel;
        actual.mux_a    = MuxASel;
        actual.mux_b    = MuxBSel;
        actual.mux_c    = MuxCSel;
        actual.mux_d    = MuxDSel;
        actual.ir_write = IR_Write;
        actual.ir_lh    = IR_LH;
        actual.mem_cs   = Mem_CS;
        actual.mem_wr   = Mem_WR;
        actual.dr_e     = DR_E;
        actual.dr_fun   = DR_FunSel;
        actual.halted   = Halted;
        actual.illegal  = IllegalOp;
        actual.st       = StateOut;
    end

    function automatic outs_t expDefault(input logic [2:0] st);
        outs_t e;
        e         = '0;
        e.rf_reg  = 4'hF;
        e.rf_scr  = 4'hF;
        e.arf_reg = 3'b111;
        e.mem_cs  = 1'b1;
        e.st      = st;
        return e;
    endfunction

    function automatic outs_t expFetch(input logic lh, input logic [2:0] st);
        outs_t e;
        e          = expDefault(st);
        e.arf_d    = 2'b00;
        e.mem_cs   = 1'b0;
        e.ir_write = 1'b1;
        e.ir_lh    = lh;
        e.arf_reg  = 3'b011;
        e.arf_fun  = ARF_INC;
        return e;
    endfunction

    function automatic outs_t expIdleStart();
        outs_t e;
        e         = expDefault(3'd0);
        e.arf_reg = 3'b011;
        e.arf_fun = ARF_CLEAR;
        return e;
    endfunction

    function automatic outs_t expHalt();
        outs_t e;
        e        = expDefault(3'd5);
        e.halted = 1'b1;
        return e;
    endfunction

    function automatic outs_t expBranch();
        outs_t e;
        e         = expDefault(3'd3);
        e.mux_b   = 2'd3;
        e.arf_reg = 3'b011;
        e.arf_fun = ARF_LOAD;
        return e;
    endfunction

    function automatic vec_t mkVec(input string name, input logic [15:0] ir, input logic [3:0] flags);
        vec_t v;
        v.name      = name;
        v.ir        = ir;
        v.flags     = flags;
        v.exec      = expDefault(3'd3);
        v.has_exec2 = 1'b0;
        v.exec2     = expDefault(3'd4);
        v.to_halt   = 1'b0;
        return v;
    endfunction

    task automatic applyStimulus(input logic [15:0] ir, input logic [3:0] flags, input logic start);
        IROut        = ir;
        ALU_FlagsOut = flags;
        Start        = start;
        #1;
    endtask

    task automatic stepClock();
        @(posedge Clock);
        #2;
    endtask

    task automatic checkOutput(input string name, input outs_t exp);
        num_checks++;
        if (actual !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got %h expected %h (state got %0d expected %0d)",
                     name, actual, exp, actual.st, exp.st);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;

        v = mkVec("imm_r1", 16'h0C45, 4'h0);
        v.exec.mux_a = 2'd3; v.exec.rf_reg = 4'b0111; v.exec.rf_fun = RF_LOADLOW;
        vecs.push_back(v);

        v = mkVec("add_r3_r1_r2", 16'h1308, 4'h0);
        v.exec.out_a = 3'd0; v.exec.out_b = 3'd1; v.exec.alu_fun = 5'h14; v.exec.alu_wf = 1'b1;
        v.exec.rf_fun = RF_LOAD; v.exec.rf_reg = 4'b1101;
        vecs.push_back(v);

        v = mkVec("add_1328", 16'h1328, 4'h0);
        v.exec.out_a = 3'd1; v.exec.out_b = 3'd1; v.exec.alu_fun = 5'h14; v.exec.alu_wf = 1'b1;
        v.exec.rf_fun = RF_LOAD; v.exec.rf_reg = 4'b1101;
        vecs.push_back(v);

        v = mkVec("sub_r1_nowf", 16'h1470, 4'h0);
        v.exec.out_a = 3'd3; v.exec.out_b = 3'd2; v.exec.alu_fun = 5'h15;
        v.exec.rf_fun = RF_LOAD; v.exec.rf_reg = 4'b0111;
        vecs.push_back(v);

        v = mkVec("and_r2", 16'h1888, 4'h0);
        v.exec.out_a = 3'd0; v.exec.out_b = 3'd1; v.exec.alu_fun = 5'h16;
        v.exec.rf_fun = RF_LOAD; v.exec.rf_reg = 4'b1011;
        vecs.push_back(v);

        v = mkVec("xor_r4", 16'h23C0, 4'h0);
        v.exec.out_a = 3'd2; v.exec.out_b = 3'd0; v.exec.alu_fun = 5'h18; v.exec.alu_wf = 1'b1;
        v.exec.rf_fun = RF_LOAD; v.exec.rf_reg = 4'b1110;
        vecs.push_back(v);

        v = mkVec("beq_z0", 16'h0810, 4'b0000);
        vecs.push_back(v);

        v = mkVec("beq_z1", 16'h0810, 4'b1000);
        v.exec = expBranch();
        vecs.push_back(v);

        v = mkVec("bne_z1", 16'h0455, 4'b1111);
        vecs.push_back(v);

        v = mkVec("bne_z0", 16'h0455, 4'b0111);
        v.exec = expBranch();
        vecs.push_back(v);

        v = mkVec("bra", 16'h0020, 4'b1000);
        v.exec = expBranch();
        vecs.push_back(v);

        v = mkVec("st_r3", 16'h2A00, 4'h0);
        v.exec.out_a = 3'd2; v.exec.alu_fun = 5'h10; v.exec.arf_d = OUT_AR;
        v.exec.mem_cs = 1'b0; v.exec.mem_wr = 1'b1;
        vecs.push_back(v);

        v = mkVec("ld_r2", 16'h2500, 4'h0);
        v.exec.arf_d = OUT_AR; v.exec.mem_cs = 1'b0; v.exec.dr_e = 1'b1; v.exec.dr_fun = DR_LOAD;
        v.has_exec2 = 1'b1;
        v.exec2.mux_a = 2'd2; v.exec2.rf_fun = RF_LOAD; v.exec2.rf_reg = 4'b1011;
        vecs.push_back(v);

        v = mkVec("illegal_0c", 16'h3000, 4'h0);
        v.exec.illegal = 1'b1; v.to_halt = TRAP;
        vecs.push_back(v);

        v = mkVec("illegal_3f", 16'hFC00, 4'h0);
        v.exec.illegal = 1'b1; v.to_halt = TRAP;
        vecs.push_back(v);

        v = mkVec("hlt", 16'h2C00, 4'h0);
        v.to_halt = 1'b1;
        vecs.push_back(v);

        // Reset and start-up
        Reset = 1'b0;
        applyStimulus(16'h0000, 4'h0, 1'b0);
        #2;
        checkOutput("reset_idle", expDefault(3'd0));
        stepClock();
        stepClock();
        Reset = 1'b1;
        stepClock();
        checkOutput("idle_no_start", expDefault(3'd0));

        applyStimulus(16'h0000, 4'h0, 1'b1);
        checkOutput("idle_start_clear_pc", expIdleStart());
        stepClock();
        applyStimulus(16'h0C45, 4'h0, 1'b0);
        checkOutput("fetch1_low", expFetch(1'b0, 3'd1));
        stepClock();
        checkOutput("fetch2_high", expFetch(1'b1, 3'd2));

        // Asynchronous reset in the middle of FETCH2
        Reset = 1'b0;
        #1;
        checkOutput("async_reset_mid_fetch2", expDefault(3'd0));
        stepClock();
        checkOutput("reset_held_idle", expDefault(3'd0));
        Reset = 1'b1;
        stepClock();

        applyStimulus(16'h0000, 4'h0, 1'b1);
        stepClock();
        applyStimulus(16'h0000, 4'h0, 1'b0);
        checkOutput("restart_fetch1", expFetch(1'b0, 3'd1));

        // Instruction table: each iteration starts in FETCH1
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ir, vecs[i].flags, 1'b0);
            stepClock();
            stepClock();
            checkOutput({vecs[i].name, "_exec"}, vecs[i].exec);
            if (vecs[i].has_exec2) begin
                stepClock();
                checkOutput({vecs[i].name, "_exec2"}, vecs[i].exec2);
            end
            stepClock();
            if (vecs[i].to_halt) begin
                checkOutput({vecs[i].name, "_halt"}, expHalt());
                applyStimulus(vecs[i].ir, vecs[i].flags, 1'b1);
                stepClock();
                checkOutput({vecs[i].name, "_idle"}, expIdleStart());
                stepClock();
                applyStimulus(vecs[i].ir, vecs[i].flags, 1'b0);
            end else begin
                checkOutput({vecs[i].name, "_next_fetch1"}, expFetch(1'b0, 3'd1));
            end
        end

        // HALT holds without Start, and reset leaves it asynchronously
        applyStimulus(16'h2C00, 4'h0, 1'b0);
        stepClock();
        stepClock();
        stepClock();
        stepClock();
        stepClock();
        stepClock();
        checkOutput("halt_hold", expHalt());
        Reset = 1'b0;
        #1;
        checkOutput("reset_from_halt", expDefault(3'd0));
        stepClock();
        Reset = 1'b1;
        stepClock();
        checkOutput("idle_after_halt_reset", expDefault(3'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
